// File: rtl/vram_arbiter.sv
// VRAM arbiter: display reads have strict priority; writer FIFO drains
// into free cycles. Optional macro: VRAM_ARB_BLANK_WRITE_EN.
//
// Ports: clk, reset (async, active-low)
//   display : disp_req, disp_addr -> disp_data, disp_valid
//   writer  : wr_valid, wr_addr, wr_data -> wr_ready
//   memory  : mem_addr, mem_wdata, mem_we <- mem_rdata
//   status  : fifo_count, starve ; blank_b used only with the macro
module vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 12,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       disp_req,
  input  logic [AW-1:0]              disp_addr,
  output logic [DW-1:0]              disp_data,
  output logic                       disp_valid,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic                       blank_b,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic                       mem_we,
  input  logic [DW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    G_IDLE,
    G_DISP,
    G_WRITE
  } gnt_t;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] scnt;
  logic          pop_ok, frz;
  logic          push, pop;
  gnt_t          gnt;

`ifdef VRAM_ARB_BLANK_WRITE_EN
  // Writes land only during blanking so a visible line never tears.
  assign pop_ok = ~blank_b;
  assign frz    = blank_b;
`else
  assign pop_ok = 1'b1;
  assign frz    = 1'b0;
`endif

  always_comb begin
    gnt = G_IDLE;
    if (disp_req)
      gnt = G_DISP;
    else if (count != '0 && pop_ok)
      gnt = G_WRITE;
  end

  assign pop      = (gnt == G_WRITE);
  assign wr_ready = (count < FULL);
  assign push     = wr_valid & wr_ready;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = disp_addr;
    mem_wdata = data_q[rd_ptr];
    unique case (1'b1)
      (gnt == G_WRITE): begin
        mem_we   = 1'b1;
        mem_addr = addr_q[rd_ptr];
      end
      (gnt == G_DISP):  mem_addr = disp_addr;
      default:          mem_addr = disp_addr;
    endcase
    // While held in reset the bus shows the (cleared) FIFO head.
    if (!reset)
      mem_addr = addr_q[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= wr_addr;
        data_q[wr_ptr] <= wr_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt   <= '0;
      starve <= 1'b0;
    end else if (count == '0 || pop) begin
      scnt <= '0;
    end else if (!frz && scnt != SMAX) begin
      scnt <= scnt + 1'b1;
      if (scnt + 1'b1 == SMAX)
        starve <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      disp_valid <= 1'b0;
    else
      disp_valid <= disp_req;
  end

  assign disp_data  = mem_rdata;
  assign fifo_count = count;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized + directed bench for vram_arbiter against a queue model.
// Provides a behavioural synchronous RAM on the memory port.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 12;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;

  logic          clk = 0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          blank_b;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    fifo_count;
  logic          starve;

  vram_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .blank_b(blank_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .fifo_count(fifo_count), .starve(starve)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [65536];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_mem [65536];
  int            sc;
  bit            m_starve;
  bit            prev_req;
  logic [DW-1:0] exp_rd;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pop_ok();
`ifdef VRAM_ARB_BLANK_WRITE_EN
    return !blank_b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit frozen();
`ifdef VRAM_ARB_BLANK_WRITE_EN
    return blank_b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    sc = 0;
    m_starve = 0;
    prev_req = 0;
  endtask

  task automatic cycle();
    bit pop, push;
    int sz;
    @(negedge clk);
    sz = q.size();
    pop = !disp_req && sz > 0 && pop_ok();
    push = wr_valid && sz < DEPTH;
    chk("wr_ready", wr_ready, sz < DEPTH);
    chk("fifo_count", fifo_count, sz);
    chk("starve", starve, m_starve);
    chk("disp_valid", disp_valid, prev_req);
    if (prev_req) chk("disp_data", disp_data, exp_rd);
    chk("mem_we", mem_we, pop);
    if (pop) begin
      chk("wr_addr_out", mem_addr, q[0].a);
      chk("wr_data_out", mem_wdata, q[0].d);
    end else begin
      chk("rd_addr_out", mem_addr, disp_addr);
    end
    if (disp_req) exp_rd = ref_mem[disp_addr];
    prev_req = disp_req;
    if (pop) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (sz == 0 || pop) sc = 0;
    else if (!frozen() && sc < SMAX) begin
      sc++;
      if (sc == SMAX) m_starve = 1;
    end
    if (push) q.push_back('{wr_addr, wr_data});
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit rq, logic [AW-1:0] ra,
                        bit wv, logic [AW-1:0] wa,
                        logic [DW-1:0] wd);
    disp_req = rq;
    disp_addr = ra;
    wr_valid = wv;
    wr_addr = wa;
    wr_data = wd;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_starve", starve, 0);
    @(posedge clk);
    #1;
    chk("rst_no_push", fifo_count, 0);
    reset = 1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    blank_b = 0;
    exp_rd = '0;
    set_in(0, 16'h0, 1, 16'h5, 12'h123);
    reset = 1;
    #2;
    do_reset();

    // first edge after release pushes
    cycle();
    chk("first_push", fifo_count, 1);
    set_in(0, 0, 0, 0, 0);
    cycle();

    // write then read
    set_in(0, 16'h0, 1, 16'h0010, 12'hF0A);
    cycle();
    set_in(0, 16'h0, 0, 0, 0);
    cycle();
    set_in(1, 16'h0010, 0, 0, 0);
    cycle();
    chk("wtr_data", disp_data, 12'hF0A);

    // priority and full
    for (int i = 0; i < 5; i++) begin
      set_in(1, 16'(i), 1, 16'(16'h100 + i), 12'(12'hA00 + i));
      cycle();
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", wr_ready, 0);
    set_in(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", fifo_count, 0);

    // simultaneous push/pop across wrap
    for (int i = 0; i < 2; i++) begin
      set_in(1, 16'h1, 1, 16'(16'h200 + i), 12'(12'hB00 + i));
      cycle();
    end
    for (int i = 0; i < 12; i++) begin
      set_in(0, 16'h1, 1, 16'(16'h210 + i), 12'(12'hC00 + i));
      cycle();
      chk("pp_count", fifo_count, 2);
    end
    set_in(0, 16'h1, 0, 0, 0);
    cycle();
    cycle();

    // starvation
    set_in(1, 16'h2, 1, 16'h300, 12'h321);
    cycle();
    set_in(1, 16'h2, 0, 0, 0);
    for (int i = 0; i < SMAX; i++) cycle();
    chk("starve_set", starve, 1);
    set_in(0, 16'h2, 0, 0, 0);
    cycle();
    cycle();
    chk("starve_sticky", starve, 1);
    do_reset();
    chk("starve_clr", starve, 0);

`ifdef VRAM_ARB_BLANK_WRITE_EN
    blank_b = 1;
    for (int i = 0; i < 2; i++) begin
      set_in(0, 16'h3, 1, 16'(16'h400 + i), 12'(12'hD00 + i));
      cycle();
    end
    set_in(0, 16'h3, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle();
    chk("blank_hold", fifo_count, 2);
    chk("blank_frz", starve, 0);
    blank_b = 0;
    cycle();
    cycle();
    chk("blank_drain", fifo_count, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) < 45, 16'($urandom_range(0, 15)),
             $urandom_range(0, 99) < 60, 16'($urandom_range(0, 15)),
             12'($urandom));
      blank_b = $urandom_range(0, 1) == 1;
      if (i == 300) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
